// File: rtl/decode_pkg.sv
// decode_pkg: opcodes, ALU/operand/next-pc encodings and the decoded control bundle
package decode_pkg;

  localparam int ALU_W = 5;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  localparam logic [ALU_W-1:0] ALU_ADD    = 5'd0;
  localparam logic [ALU_W-1:0] ALU_SUB    = 5'd1;
  localparam logic [ALU_W-1:0] ALU_SLL    = 5'd2;
  localparam logic [ALU_W-1:0] ALU_SLT    = 5'd3;
  localparam logic [ALU_W-1:0] ALU_SLTU   = 5'd4;
  localparam logic [ALU_W-1:0] ALU_XOR    = 5'd5;
  localparam logic [ALU_W-1:0] ALU_SRL    = 5'd6;
  localparam logic [ALU_W-1:0] ALU_SRA    = 5'd7;
  localparam logic [ALU_W-1:0] ALU_OR     = 5'd8;
  localparam logic [ALU_W-1:0] ALU_AND    = 5'd9;
  localparam logic [ALU_W-1:0] ALU_PASS_B = 5'd10;
  // M ops are contiguous so funct3 can be added to ALU_MUL
  localparam logic [ALU_W-1:0] ALU_MUL    = 5'd11;
  localparam logic [ALU_W-1:0] ALU_MULH   = 5'd12;
  localparam logic [ALU_W-1:0] ALU_MULHSU = 5'd13;
  localparam logic [ALU_W-1:0] ALU_MULHU  = 5'd14;
  localparam logic [ALU_W-1:0] ALU_DIV    = 5'd15;
  localparam logic [ALU_W-1:0] ALU_DIVU   = 5'd16;
  localparam logic [ALU_W-1:0] ALU_REM    = 5'd17;
  localparam logic [ALU_W-1:0] ALU_REMU   = 5'd18;

  localparam logic [1:0] SRC2_RS2  = 2'b00;
  localparam logic [1:0] SRC2_IMM  = 2'b01;
  localparam logic [1:0] SRC2_FOUR = 2'b11;

  localparam logic [1:0] NEXTPC_SEQ    = 2'b00;
  localparam logic [1:0] NEXTPC_PCIMM  = 2'b01;
  localparam logic [1:0] NEXTPC_RS1IMM = 2'b11;

  typedef struct packed {
    logic [4:0]       rs1_id;
    logic [4:0]       rs2_id;
    logic [4:0]       rd_id;
    logic [2:0]       mem_width;
    logic [ALU_W-1:0] alu_op;
    logic             mem_to_reg;
    logic             mem_write;
    logic             reg_write;
    logic             alu_src1;
    logic [1:0]       alu_src2;
    logic             branch;
    logic             inv_branch;
    logic [1:0]       next_pc;
    logic             illegal;
  } decode_ctrl_t;

  // Base integer op selected by funct3; alt picks SUB/SRA
  function automatic logic [ALU_W-1:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_core.sv
// decode_core: combinational instruction word -> control bundle and immediate
module decode_core
  import decode_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int SUPPORT_M = 0
) (
  input  logic [31:0]     instr,
  output decode_ctrl_t    ctrl,
  output logic [XLEN-1:0] imm
);

  localparam int SHW = (XLEN == 64) ? 6 : 5;

  logic [6:0] opcode, f7, sh_f;
  logic [2:0] f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  logic ill, r_ok, m_op;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  // RV64 shifts use a 6-bit shamt, so only funct6 is checked there
  assign sh_f   = (XLEN == 64) ? {instr[31:26], 1'b0} : instr[31:25];
  assign m_op   = (SUPPORT_M != 0) && f7 == 7'b0000001;
  assign r_ok   = f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) || m_op;

  assign imm_i  = XLEN'($signed(instr[31:20]));
  assign imm_s  = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_b  = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_u  = XLEN'($signed({instr[31:12], 12'b0}));
  assign imm_j  = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
  assign imm_sh = XLEN'(instr[20 +: SHW]);

  // Full decode; every opcode not listed is illegal and illegal entries carry no side effects
  always_comb begin
    ctrl        = '0;
    ctrl.rs1_id = instr[19:15];
    ctrl.rs2_id = instr[24:20];
    ctrl.rd_id  = instr[11:7];
    imm         = '0;
    ill         = 1'b0;
    case (opcode)
      OP_LUI: begin
        ctrl.alu_op    = ALU_PASS_B;
        ctrl.alu_src2  = SRC2_IMM;
        ctrl.reg_write = 1'b1;
        imm            = imm_u;
      end
      OP_AUIPC: begin
        ctrl.alu_src1  = 1'b1;
        ctrl.alu_src2  = SRC2_IMM;
        ctrl.reg_write = 1'b1;
        imm            = imm_u;
      end
      OP_JAL, OP_JALR: begin
        ctrl.alu_src1  = 1'b1;
        ctrl.alu_src2  = SRC2_FOUR;
        ctrl.reg_write = 1'b1;
        ctrl.branch    = 1'b1;
        ctrl.next_pc   = (opcode == OP_JAL) ? NEXTPC_PCIMM : NEXTPC_RS1IMM;
        imm            = (opcode == OP_JAL) ? imm_j : imm_i;
        ill            = (opcode == OP_JALR) && f3 != 3'b000;
      end
      OP_BRANCH: begin
        // execute takes the branch when (alu result != 0) ^ inv_branch
        ctrl.alu_op     = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
        ctrl.inv_branch = f3[2] ? f3[0] : !f3[0];
        ctrl.branch     = 1'b1;
        ctrl.next_pc    = NEXTPC_PCIMM;
        imm             = imm_b;
        ill             = f3[2:1] == 2'b01;
      end
      OP_LOAD: begin
        ctrl.alu_src2   = SRC2_IMM;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_width  = f3;
        imm             = imm_i;
        ill             = f3 == 3'b111 || (XLEN == 32 && (f3 == 3'b011 || f3 == 3'b110));
      end
      OP_STORE: begin
        ctrl.alu_src2  = SRC2_IMM;
        ctrl.mem_write = 1'b1;
        ctrl.mem_width = f3;
        imm            = imm_s;
        ill            = f3[2] || (XLEN == 32 && f3 == 3'b011);
      end
      OP_IMM: begin
        ctrl.alu_op    = alu_from_f3(f3, f3 == 3'b101 && instr[30]);
        ctrl.alu_src2  = SRC2_IMM;
        ctrl.reg_write = 1'b1;
        imm            = (f3 == 3'b001 || f3 == 3'b101) ? imm_sh : imm_i;
        ill            = f3 == 3'b001 ? sh_f != 7'b0 :
                         f3 == 3'b101 ? !(sh_f == 7'b0 || sh_f == 7'b0100000) : 1'b0;
      end
      OP_REG: begin
        ctrl.alu_op    = m_op ? ALU_W'(ALU_MUL + ALU_W'(f3)) : alu_from_f3(f3, instr[30]);
        ctrl.reg_write = 1'b1;
        ill            = !r_ok;
      end
      OP_FENCE: ill = 1'b0;
      default:  ill = 1'b1;
    endcase
    ctrl.illegal = ill;
    if (ill) begin
      ctrl.reg_write = 1'b0;
      ctrl.mem_write = 1'b0;
      ctrl.branch    = 1'b0;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered decode with valid/ready handshake and a 2-entry skid buffer
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int SUPPORT_M = 0,
  parameter int ALU_OP_W  = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [XLEN-1:0]     in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_pc,
  output logic [4:0]          rs1_id,
  output logic [4:0]          rs2_id,
  output logic [4:0]          rd_id,
  output logic [XLEN-1:0]     imm,
  output logic [2:0]          mem_width,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                mem_to_reg,
  output logic                mem_write,
  output logic                reg_write,
  output logic                alu_src1,
  output logic [1:0]          alu_src2,
  output logic                branch,
  output logic                inv_branch,
  output logic [1:0]          next_pc,
  output logic                illegal
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t state;
  decode_ctrl_t dec_ctrl, out_ctrl, sk_ctrl;
  logic [XLEN-1:0] dec_imm, out_imm, sk_imm, out_pc_q, sk_pc;
  logic take_in, take_out;

  decode_core #(.XLEN(XLEN), .SUPPORT_M(SUPPORT_M)) u_core (
    .instr(in_instr),
    .ctrl (dec_ctrl),
    .imm  (dec_imm)
  );

  assign in_ready  = state != S_TWO;
  assign out_valid = state != S_EMPTY;
  assign take_in   = in_valid && in_ready && !flush;
  assign take_out  = out_valid && out_ready;

  // Occupancy FSM plus output/skid registers; new data goes to the output register
  // whenever it is (or is about to become) free, otherwise into the skid slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_EMPTY;
      out_ctrl <= '0;
      out_imm  <= '0;
      out_pc_q <= '0;
      sk_ctrl  <= '0;
      sk_imm   <= '0;
      sk_pc    <= '0;
    end else if (flush) begin
      state <= S_EMPTY;
    end else begin
      if (take_in && (state == S_EMPTY || take_out)) begin
        out_ctrl <= dec_ctrl;
        out_imm  <= dec_imm;
        out_pc_q <= in_pc;
      end else if (take_in) begin
        sk_ctrl <= dec_ctrl;
        sk_imm  <= dec_imm;
        sk_pc   <= in_pc;
      end else if (take_out && state == S_TWO) begin
        out_ctrl <= sk_ctrl;
        out_imm  <= sk_imm;
        out_pc_q <= sk_pc;
      end
      if (take_in && !take_out)
        state <= (state == S_EMPTY) ? S_ONE : S_TWO;
      else if (!take_in && take_out)
        state <= (state == S_TWO) ? S_ONE : S_EMPTY;
    end
  end

  assign out_pc     = out_pc_q;
  assign imm        = out_imm;
  assign rs1_id     = out_ctrl.rs1_id;
  assign rs2_id     = out_ctrl.rs2_id;
  assign rd_id      = out_ctrl.rd_id;
  assign mem_width  = out_ctrl.mem_width;
  assign alu_op     = ALU_OP_W'(out_ctrl.alu_op);
  assign mem_to_reg = out_ctrl.mem_to_reg;
  assign mem_write  = out_ctrl.mem_write;
  assign reg_write  = out_ctrl.reg_write;
  assign alu_src1   = out_ctrl.alu_src1;
  assign alu_src2   = out_ctrl.alu_src2;
  assign branch     = out_ctrl.branch;
  assign inv_branch = out_ctrl.inv_branch;
  assign next_pc    = out_ctrl.next_pc;
  assign illegal    = out_ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors, handshake corner cases and random scoreboard for decode_stage
module tb_decode_stage;
  import decode_pkg::*;

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0, in_pc = '0;
  logic in_ready, out_valid, mem_to_reg, mem_write, reg_write, alu_src1, branch, inv_branch, illegal;
  logic [31:0] out_pc, imm;
  logic [4:0] rs1_id, rs2_id, rd_id, alu_op;
  logic [2:0] mem_width;
  logic [1:0] alu_src2, next_pc;
  logic z_in_ready, z_out_valid, z_mem_to_reg, z_mem_write, z_reg_write, z_alu_src1, z_branch, z_inv_branch, z_illegal;
  logic [31:0] z_out_pc, z_imm;
  logic [4:0] z_rs1_id, z_rs2_id, z_rd_id, z_alu_op;
  logic [2:0] z_mem_width;
  logic [1:0] z_alu_src2, z_next_pc;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .SUPPORT_M(1), .ALU_OP_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id), .imm(imm),
    .mem_width(mem_width), .alu_op(alu_op), .mem_to_reg(mem_to_reg), .mem_write(mem_write),
    .reg_write(reg_write), .alu_src1(alu_src1), .alu_src2(alu_src2), .branch(branch),
    .inv_branch(inv_branch), .next_pc(next_pc), .illegal(illegal)
  );

  decode_stage #(.XLEN(32), .SUPPORT_M(0), .ALU_OP_W(5)) dut_nom (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(z_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(z_out_valid), .out_ready(out_ready),
    .out_pc(z_out_pc), .rs1_id(z_rs1_id), .rs2_id(z_rs2_id), .rd_id(z_rd_id), .imm(z_imm),
    .mem_width(z_mem_width), .alu_op(z_alu_op), .mem_to_reg(z_mem_to_reg), .mem_write(z_mem_write),
    .reg_write(z_reg_write), .alu_src1(z_alu_src1), .alu_src2(z_alu_src2), .branch(z_branch),
    .inv_branch(z_inv_branch), .next_pc(z_next_pc), .illegal(z_illegal)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference decoder: mnemonic match table in the style of the ISA opcode listings
  localparam logic [2:0] F_NONE = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3, F_U = 3'd4, F_J = 3'd5, F_SH = 3'd6;

  typedef struct packed {
    logic       ill, rw, mw, ml, br;
    logic [4:0] alu;
    logic [2:0] fmt;
  } mdl_t;

  function automatic mdl_t mk(input logic [4:0] alu, input logic [2:0] fmt, input logic rw, mw, ml, br);
    return '{ill: 1'b0, rw: rw, mw: mw, ml: ml, br: br, alu: alu, fmt: fmt};
  endfunction

  function automatic mdl_t model(input logic [31:0] i);
    mdl_t m = '{ill: 1'b1, default: '0};
    casez (i)
      {25'b?, OP_LUI}:                               m = mk(ALU_PASS_B, F_U, 1, 0, 0, 0);
      {25'b?, OP_AUIPC}:                             m = mk(ALU_ADD,    F_U, 1, 0, 0, 0);
      {25'b?, OP_JAL}:                               m = mk(ALU_ADD,    F_J, 1, 0, 0, 1);
      {17'b?, 3'b000, 5'b?, OP_JALR}:                m = mk(ALU_ADD,    F_I, 1, 0, 0, 1);
      {17'b?, 3'b000, 5'b?, OP_BRANCH}:              m = mk(ALU_SUB,    F_B, 0, 0, 0, 1);
      {17'b?, 3'b001, 5'b?, OP_BRANCH}:              m = mk(ALU_SUB,    F_B, 0, 0, 0, 1);
      {17'b?, 3'b100, 5'b?, OP_BRANCH}:              m = mk(ALU_SLT,    F_B, 0, 0, 0, 1);
      {17'b?, 3'b101, 5'b?, OP_BRANCH}:              m = mk(ALU_SLT,    F_B, 0, 0, 0, 1);
      {17'b?, 3'b110, 5'b?, OP_BRANCH}:              m = mk(ALU_SLTU,   F_B, 0, 0, 0, 1);
      {17'b?, 3'b111, 5'b?, OP_BRANCH}:              m = mk(ALU_SLTU,   F_B, 0, 0, 0, 1);
      {17'b?, 3'b000, 5'b?, OP_LOAD},
      {17'b?, 3'b001, 5'b?, OP_LOAD},
      {17'b?, 3'b010, 5'b?, OP_LOAD},
      {17'b?, 3'b100, 5'b?, OP_LOAD},
      {17'b?, 3'b101, 5'b?, OP_LOAD}:                m = mk(ALU_ADD,    F_I, 1, 0, 1, 0);
      {17'b?, 3'b000, 5'b?, OP_STORE},
      {17'b?, 3'b001, 5'b?, OP_STORE},
      {17'b?, 3'b010, 5'b?, OP_STORE}:               m = mk(ALU_ADD,    F_S, 0, 1, 0, 0);
      {17'b?, 3'b000, 5'b?, OP_IMM}:                 m = mk(ALU_ADD,    F_I, 1, 0, 0, 0);
      {17'b?, 3'b010, 5'b?, OP_IMM}:                 m = mk(ALU_SLT,    F_I, 1, 0, 0, 0);
      {17'b?, 3'b011, 5'b?, OP_IMM}:                 m = mk(ALU_SLTU,   F_I, 1, 0, 0, 0);
      {17'b?, 3'b100, 5'b?, OP_IMM}:                 m = mk(ALU_XOR,    F_I, 1, 0, 0, 0);
      {17'b?, 3'b110, 5'b?, OP_IMM}:                 m = mk(ALU_OR,     F_I, 1, 0, 0, 0);
      {17'b?, 3'b111, 5'b?, OP_IMM}:                 m = mk(ALU_AND,    F_I, 1, 0, 0, 0);
      {7'b0000000, 10'b?, 3'b001, 5'b?, OP_IMM}:     m = mk(ALU_SLL,    F_SH, 1, 0, 0, 0);
      {7'b0000000, 10'b?, 3'b101, 5'b?, OP_IMM}:     m = mk(ALU_SRL,    F_SH, 1, 0, 0, 0);
      {7'b0100000, 10'b?, 3'b101, 5'b?, OP_IMM}:     m = mk(ALU_SRA,    F_SH, 1, 0, 0, 0);
      {7'b0000000, 10'b?, 3'b000, 5'b?, OP_REG}:     m = mk(ALU_ADD,    F_NONE, 1, 0, 0, 0);
      {7'b0100000, 10'b?, 3'b000, 5'b?, OP_REG}:     m = mk(ALU_SUB,    F_NONE, 1, 0, 0, 0);
      {7'b0000000, 10'b?, 3'b001, 5'b?, OP_REG}:     m = mk(ALU_SLL,    F_NONE, 1, 0, 0, 0);
      {7'b0000000, 10'b?, 3'b010, 5'b?, OP_REG}:     m = mk(ALU_SLT,    F_NONE, 1, 0, 0, 0);
      {7'b0000000, 10'b?, 3'b011, 5'b?, OP_REG}:     m = mk(ALU_SLTU,   F_NONE, 1, 0, 0, 0);
      {7'b0000000, 10'b?, 3'b100, 5'b?, OP_REG}:     m = mk(ALU_XOR,    F_NONE, 1, 0, 0, 0);
      {7'b0000000, 10'b?, 3'b101, 5'b?, OP_REG}:     m = mk(ALU_SRL,    F_NONE, 1, 0, 0, 0);
      {7'b0100000, 10'b?, 3'b101, 5'b?, OP_REG}:     m = mk(ALU_SRA,    F_NONE, 1, 0, 0, 0);
      {7'b0000000, 10'b?, 3'b110, 5'b?, OP_REG}:     m = mk(ALU_OR,     F_NONE, 1, 0, 0, 0);
      {7'b0000000, 10'b?, 3'b111, 5'b?, OP_REG}:     m = mk(ALU_AND,    F_NONE, 1, 0, 0, 0);
      {7'b0000001, 10'b?, 3'b000, 5'b?, OP_REG}:     m = mk(ALU_MUL,    F_NONE, 1, 0, 0, 0);
      {7'b0000001, 10'b?, 3'b001, 5'b?, OP_REG}:     m = mk(ALU_MULH,   F_NONE, 1, 0, 0, 0);
      {7'b0000001, 10'b?, 3'b010, 5'b?, OP_REG}:     m = mk(ALU_MULHSU, F_NONE, 1, 0, 0, 0);
      {7'b0000001, 10'b?, 3'b011, 5'b?, OP_REG}:     m = mk(ALU_MULHU,  F_NONE, 1, 0, 0, 0);
      {7'b0000001, 10'b?, 3'b100, 5'b?, OP_REG}:     m = mk(ALU_DIV,    F_NONE, 1, 0, 0, 0);
      {7'b0000001, 10'b?, 3'b101, 5'b?, OP_REG}:     m = mk(ALU_DIVU,   F_NONE, 1, 0, 0, 0);
      {7'b0000001, 10'b?, 3'b110, 5'b?, OP_REG}:     m = mk(ALU_REM,    F_NONE, 1, 0, 0, 0);
      {7'b0000001, 10'b?, 3'b111, 5'b?, OP_REG}:     m = mk(ALU_REMU,   F_NONE, 1, 0, 0, 0);
      {25'b?, OP_FENCE}:                             m = mk(ALU_ADD,    F_NONE, 0, 0, 0, 0);
      default:                                       m = '{ill: 1'b1, default: '0};
    endcase
    return m;
  endfunction

  function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
    return 32'($signed(v << (32 - bits)) >>> (32 - bits));
  endfunction

  function automatic logic [31:0] model_imm(input logic [31:0] i, input logic [2:0] fmt);
    case (fmt)
      F_I:     return sx({20'b0, i[31:20]}, 12);
      F_S:     return sx({20'b0, i[31:25], i[11:7]}, 12);
      F_B:     return sx({19'b0, i[31], i[7], i[30:25], i[11:8], 1'b0}, 13);
      F_U:     return {i[31:12], 12'h000};
      F_J:     return sx({11'b0, i[31], i[19:12], i[20], i[30:21], 1'b0}, 21);
      default: return {27'b0, i[24:20]};
    endcase
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic        ill, ill_nom, rw, mw, br;
    logic [4:0]  alu;
    logic [1:0]  src2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        chk_imm;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } txn_t;

  txn_t sb[$];

  task automatic put(input logic v, input logic [31:0] ins, input logic r);
    @(negedge clk);
    in_valid  = v;
    in_instr  = ins;
    out_ready = r;
    flush     = 1'b0;
  endtask

  initial begin
    vec_t vt[12];
    logic [4:0] got[$];
    int idx;
    logic [31:0] seq[3];
    vt[0]  = '{32'hFFF10093, 0, 0, 1, 0, 0, ALU_ADD,    2'b01, 5'd1,  32'hFFFFFFFF, 1};
    vt[1]  = '{32'h00000000, 1, 1, 0, 0, 0, ALU_ADD,    2'b00, 5'd0,  32'h0,        0};
    vt[2]  = '{32'h4020F1B3, 1, 1, 0, 0, 0, ALU_ADD,    2'b00, 5'd0,  32'h0,        0};
    vt[3]  = '{32'h022081B3, 0, 1, 1, 0, 0, ALU_MUL,    2'b00, 5'd3,  32'h0,        0};
    vt[4]  = '{32'h0020A423, 0, 0, 0, 1, 0, ALU_ADD,    2'b01, 5'd8,  32'h00000008, 1};
    vt[5]  = '{32'hFE208EE3, 0, 0, 0, 0, 1, ALU_SUB,    2'b00, 5'd29, 32'hFFFFFFFC, 1};
    vt[6]  = '{32'h123452B7, 0, 0, 1, 0, 0, ALU_PASS_B, 2'b01, 5'd5,  32'h12345000, 1};
    vt[7]  = '{32'h008000EF, 0, 0, 1, 0, 1, ALU_ADD,    2'b11, 5'd1,  32'h00000008, 1};
    vt[8]  = '{32'h40315093, 0, 0, 1, 0, 0, ALU_SRA,    2'b01, 5'd1,  32'h00000003, 1};
    vt[9]  = '{32'hFE20AEE3, 1, 1, 0, 0, 0, ALU_ADD,    2'b00, 5'd0,  32'h0,        0};
    vt[10] = '{32'hFF812183, 0, 0, 1, 0, 0, ALU_ADD,    2'b01, 5'd3,  32'hFFFFFFF8, 1};
    vt[11] = '{32'h02009093, 1, 1, 0, 0, 0, ALU_ADD,    2'b00, 5'd0,  32'h0,        0};

    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_bundle", {reg_write, illegal, branch, mem_write, imm, rd_id, alu_op}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors: one instruction per two cycles, checked one cycle after acceptance
    foreach (vt[k]) begin
      put(1'b1, vt[k].instr, 1'b1);
      put(1'b0, 32'h0, 1'b1);
      #1;
      check($sformatf("vec%0d_valid", k), out_valid, 1);
      check($sformatf("vec%0d_illegal", k), illegal, vt[k].ill);
      check($sformatf("vec%0d_nom_illegal", k), z_illegal, vt[k].ill_nom);
      check($sformatf("vec%0d_ctl", k), {reg_write, mem_write, branch}, {vt[k].rw, vt[k].mw, vt[k].br});
      if (!vt[k].ill) begin
        check($sformatf("vec%0d_alu", k), alu_op, vt[k].alu);
        check($sformatf("vec%0d_src2", k), alu_src2, vt[k].src2);
        check($sformatf("vec%0d_rd", k), rd_id, vt[k].rd);
      end
      if (vt[k].chk_imm) check($sformatf("vec%0d_imm", k), imm, vt[k].imm);
      if (k == 0) check("vec0_rs1", rs1_id, 5'd2);
    end

    // Back-pressure: three back-to-back instructions, consumer stalled for three cycles
    seq = '{32'h00100093, 32'h00100113, 32'h00100193};
    idx = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      out_ready = k >= 3;
      in_valid  = idx < 3;
      in_instr  = seq[idx % 3];
      #1;
      if (k == 2) check("skid_in_ready_low", in_ready, 0);
      if (out_valid && out_ready) got.push_back(rd_id);
      if (in_valid && in_ready) idx++;
    end
    check("skid_count", got.size(), 3);
    for (int k = 0; k < 3; k++) check($sformatf("skid_order%0d", k), (k < got.size()) ? got[k] : 5'h1f, 5'(k + 1));

    // Flush from the full state with a simultaneous input
    put(1'b1, 32'h00100093, 1'b0);
    put(1'b1, 32'h00100113, 1'b0);
    put(1'b1, 32'h00100393, 1'b0);
    flush = 1'b1;
    put(1'b0, 32'h0, 1'b1);
    #1;
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    for (int k = 0; k < 3; k++) begin
      put(1'b0, 32'h0, 1'b1);
      #1;
      check($sformatf("flush_gone%0d", k), out_valid, 0);
    end

    // Asynchronous reset between clock edges while one entry is held
    put(1'b1, 32'hFFF10093, 1'b0);
    put(1'b0, 32'h0, 1'b0);
    #1;
    check("arst_pre_valid", out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    put(1'b1, 32'h12345137, 1'b1);
    put(1'b0, 32'h0, 1'b1);
    #1;
    check("arst_resume_valid", out_valid, 1);
    check("arst_resume_imm", imm, 32'h12345000);
    put(1'b0, 32'h0, 1'b1);

    // Random traffic against the reference model and a FIFO scoreboard
    for (int n = 0; n < 3000; n++) begin
      logic [6:0] ops[11];
      logic [6:0] f7s[4];
      logic [31:0] r;
      ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_FENCE, 7'h0};
      r = $urandom;
      ops[10] = r[31:25];
      f7s = '{7'b0000000, 7'b0100000, 7'b0000001, r[6:0]};
      @(negedge clk);
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      flush     = $urandom_range(0, 31) == 0;
      r         = $urandom;
      in_instr  = {f7s[r[1:0]], r[24:12], r[11:7], ops[$urandom_range(0, 10)]};
      in_pc     = $urandom & 32'hFFFF_FFFC;
      #1;
      check("rnd_out_valid", out_valid, sb.size() != 0);
      check("rnd_in_ready", in_ready, sb.size() < 2);
      if (!flush && out_valid && out_ready && sb.size() != 0) begin
        txn_t t;
        mdl_t m;
        t = sb.pop_front();
        m = model(t.instr);
        check("rnd_pc", out_pc, t.pc);
        check("rnd_rd", rd_id, t.instr[11:7]);
        check("rnd_ctl", {illegal, reg_write, mem_write, mem_to_reg & !illegal, branch}, {m.ill, m.rw, m.mw, m.ml, m.br});
        if (!m.ill) check("rnd_alu", alu_op, m.alu);
        if (!m.ill && m.fmt != F_NONE) check("rnd_imm", imm, model_imm(t.instr, m.fmt));
      end
      if (!flush && in_valid && in_ready) sb.push_back('{in_instr, in_pc});
      if (flush) sb.delete();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
